rom_cache: RTL

Direct-mapped read cache between the PCE core's byte-wide ROM port and the 64-bit ROM storage backend (DDR3 or SDRAM path). Each line holds one aligned 8-byte backend word. Hits return in one cycle with no backend traffic; misses issue a single line fill. A flush input invalidates all contents when a new ROM image is downloaded.

---
 rtl/rom_cache.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/rom_cache.sv
// Direct-mapped byte-read cache in front of a 64-bit ROM backend, one 8-byte word per line.
// Define ROM_CACHE_PREFETCH_EN to prefetch the next sequential line after each demand fill.
module rom_cache #(
    parameter int LINES = 16,
    parameter int AW    = 22
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          rd,
    input  logic [AW-1:0] addr,
    output logic [7:0]    dout,
    output logic          rdy,
    input  logic          flush,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [63:0]   mem_din,
    input  logic          mem_rdy
);

    localparam int IW = $clog2(LINES);
    localparam int TW = AW - 3 - IW;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_PWAIT = 2'd3;

    logic [63:0]      data_mem_r [LINES];
    logic [TW-1:0]    tag_mem_r  [LINES];
    logic [LINES-1:0] valid_r;

    logic [1:0]    state_r;
    logic [7:0]    dout_r;
    logic          rdy_r;
    logic          mem_rd_r;
    logic [AW-1:0] mem_addr_r;
    logic [AW-1:0] lat_addr_r;
    logic          flush_pend_r;
    logic          rd_pend_r;
    logic [IW-1:0] flush_idx_r;

    logic [IW-1:0] idx_s;
    logic [TW-1:0] tag_s;
    logic          hit_s;
    logic [IW-1:0] fill_idx_s;
    logic [TW-1:0] fill_tag_s;
    logic          fill_commit_s;
    logic          pf_busy_s;
    logic          line_we_s;
    logic [IW-1:0] line_idx_s;
    logic [TW-1:0] line_tag_s;

    function automatic logic [7:0] sel_byte(input logic [63:0] w, input logic [2:0] off);
        sel_byte = w[{off, 3'b000} +: 8];
    endfunction

    assign idx_s      = addr[IW+2:3];
    assign tag_s      = addr[AW-1:IW+3];
    assign hit_s      = valid_r[idx_s] && (tag_mem_r[idx_s] == tag_s);
    assign fill_idx_s = lat_addr_r[IW+2:3];
    assign fill_tag_s = lat_addr_r[AW-1:IW+3];

    // A demand fill is not cached when a flush arrived while it was outstanding
    assign fill_commit_s = (state_r == ST_FILL) && mem_rdy && !flush && !flush_pend_r;

`ifdef ROM_CACHE_PREFETCH_EN
    logic          pf_pend_r;
    logic          pf_active_r;
    logic [AW-1:0] pf_addr_r;
    logic [IW-1:0] pf_idx_s;
    logic [TW-1:0] pf_tag_s;
    logic          pf_present_s;
    logic          pf_commit_s;

    assign pf_idx_s     = pf_addr_r[IW+2:3];
    assign pf_tag_s     = pf_addr_r[AW-1:IW+3];
    assign pf_present_s = valid_r[pf_idx_s] && (tag_mem_r[pf_idx_s] == pf_tag_s);
    assign pf_busy_s    = pf_active_r && !mem_rdy;
    assign pf_commit_s  = pf_active_r && mem_rdy && !flush &&
                          ((state_r == ST_IDLE) || ((state_r == ST_PWAIT) && !flush_pend_r));
`else
    assign pf_busy_s = 1'b0;
`endif

    // Select which completed fill, if any, is written into the line arrays
    always_comb begin
        line_we_s  = 1'b0;
        line_idx_s = fill_idx_s;
        line_tag_s = fill_tag_s;
        if (fill_commit_s) begin
            line_we_s = 1'b1;
        end
`ifdef ROM_CACHE_PREFETCH_EN
        else if (pf_commit_s) begin
            line_we_s  = 1'b1;
            line_idx_s = pf_idx_s;
            line_tag_s = pf_tag_s;
        end
`endif
        else begin
            line_we_s = 1'b0;
        end
    end

    // Line data and tag storage; validity is tracked separately so these need no reset
    always_ff @(posedge clk_sys) begin
        if (line_we_s) begin
            data_mem_r[line_idx_s] <= mem_din;
            tag_mem_r[line_idx_s]  <= line_tag_s;
        end
    end

    // Control state machine, valid bits and registered outputs
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            dout_r       <= 8'h00;
            rdy_r        <= 1'b1;
            mem_rd_r     <= 1'b0;
            mem_addr_r   <= '0;
            lat_addr_r   <= '0;
            valid_r      <= '0;
            flush_pend_r <= 1'b0;
            rd_pend_r    <= 1'b0;
            flush_idx_r  <= '0;
`ifdef ROM_CACHE_PREFETCH_EN
            pf_pend_r    <= 1'b0;
            pf_active_r  <= 1'b0;
            pf_addr_r    <= '0;
`endif
        end else begin
`ifdef ROM_CACHE_PREFETCH_EN
            if (pf_active_r && mem_rdy) begin
                pf_active_r <= 1'b0;
                mem_rd_r    <= 1'b0;
            end
            if (pf_commit_s) begin
                valid_r[pf_idx_s] <= 1'b1;
            end
`endif
            case (state_r)
                ST_IDLE: begin
                    if (flush) begin
                        rd_pend_r   <= rd;
                        lat_addr_r  <= addr;
                        rdy_r       <= 1'b0;
                        flush_idx_r <= '0;
                        if (pf_busy_s) begin
                            flush_pend_r <= 1'b1;
                            state_r      <= ST_PWAIT;
                        end else begin
                            flush_pend_r <= 1'b0;
                            state_r      <= ST_FLUSH;
                        end
                    end else if (rd && hit_s) begin
                        dout_r <= sel_byte(data_mem_r[idx_s], addr[2:0]);
                    end else if (rd) begin
                        lat_addr_r   <= addr;
                        rdy_r        <= 1'b0;
                        flush_pend_r <= 1'b0;
                        if (pf_busy_s) begin
                            rd_pend_r <= 1'b1;
                            state_r   <= ST_PWAIT;
                        end else begin
                            mem_rd_r   <= 1'b1;
                            mem_addr_r <= {addr[AW-1:3], 3'b000};
                            state_r    <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (flush) begin
                        flush_pend_r <= 1'b1;
                    end
                    if (mem_rdy) begin
                        mem_rd_r <= 1'b0;
                        dout_r   <= sel_byte(mem_din, lat_addr_r[2:0]);
                        if (flush || flush_pend_r) begin
                            flush_pend_r <= 1'b0;
                            rd_pend_r    <= 1'b0;
                            flush_idx_r  <= '0;
                            state_r      <= ST_FLUSH;
                        end else begin
                            valid_r[fill_idx_s] <= 1'b1;
                            rdy_r               <= 1'b1;
                            state_r             <= ST_IDLE;
                        end
                    end
                end
                ST_FLUSH: begin
                    valid_r[flush_idx_r] <= 1'b0;
                    if (flush) begin
                        flush_idx_r <= '0;
                    end else if (flush_idx_r == IW'(LINES - 1)) begin
                        if (rd_pend_r) begin
                            rd_pend_r  <= 1'b0;
                            mem_rd_r   <= 1'b1;
                            mem_addr_r <= {lat_addr_r[AW-1:3], 3'b000};
                            state_r    <= ST_FILL;
                        end else begin
                            rdy_r   <= 1'b1;
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        flush_idx_r <= flush_idx_r + 1'b1;
                    end
                end
                ST_PWAIT: begin
                    // Only reachable with prefetch: wait out the prefetch, then flush or demand-fill
                    if (flush) begin
                        flush_pend_r <= 1'b1;
                    end
                    if (mem_rdy) begin
                        if (flush || flush_pend_r) begin
                            flush_pend_r <= 1'b0;
                            flush_idx_r  <= '0;
                            state_r      <= ST_FLUSH;
                        end else begin
                            rd_pend_r  <= 1'b0;
                            mem_rd_r   <= 1'b1;
                            mem_addr_r <= {lat_addr_r[AW-1:3], 3'b000};
                            state_r    <= ST_FILL;
                        end
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    rdy_r    <= 1'b1;
                    mem_rd_r <= 1'b0;
                end
            endcase
`ifdef ROM_CACHE_PREFETCH_EN
            if (fill_commit_s) begin
                pf_pend_r <= 1'b1;
                pf_addr_r <= {lat_addr_r[AW-1:3] + (AW-3)'(1), 3'b000};
            end else if ((state_r == ST_IDLE) && pf_pend_r) begin
                pf_pend_r <= 1'b0;
                if (!flush && !(rd && !hit_s) && !pf_active_r && !pf_present_s) begin
                    mem_rd_r    <= 1'b1;
                    mem_addr_r  <= pf_addr_r;
                    pf_active_r <= 1'b1;
                end
            end
`endif
        end
    end

    assign dout     = dout_r;
    assign rdy      = rdy_r;
    assign mem_rd   = mem_rd_r;
    assign mem_addr = mem_addr_r;

endmodule
